// File: rtl/median_seq.sv
// median_seq: loads a 9-pixel burst into a compare-exchange core and sequences
// the sweep schedule that leaves the 5th-ranked value in the core's top register.
// Optional macro MEDIAN_SEQ_PROTO_CHECK_EN adds the sticky ERR protocol flag.

// med_core: 9-deep register chain with a compare-exchange at the top.
// dsi=1: shift di in at the bottom. byp=1 (dsi=0): shift up, top is discarded,
// a zero enters the bottom. byp=0: top keeps max(top, r[N-2]), min re-enters bottom.
module med_core #(
  parameter int WIDTH  = 8,
  parameter int NUMBER = 9
) (
  input  logic             clk,
  input  logic             dsi,
  input  logic             byp,
  input  logic [WIDTH-1:0] di,
  output logic [WIDTH-1:0] top
);

  logic [WIDTH-1:0] r [NUMBER];
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // compare the top against the register just below it
  always_comb begin
    hi = r[NUMBER-1];
    lo = r[NUMBER-2];
    if (r[NUMBER-2] > r[NUMBER-1]) begin
      hi = r[NUMBER-2];
      lo = r[NUMBER-1];
    end
  end

  // the lower eight registers form a ring; the top register is the running maximum
  always_ff @(posedge clk) begin
    for (int i = 1; i < NUMBER - 1; i++) begin
      r[i] <= r[i-1];
    end
    if (dsi) begin
      r[0]        <= di;
      r[NUMBER-1] <= r[NUMBER-2];
    end else if (byp) begin
      // the zero filler never beats a surviving value, so it cannot perturb the max
      r[0]        <= '0;
      r[NUMBER-1] <= r[NUMBER-2];
    end else begin
      r[0]        <= lo;
      r[NUMBER-1] <= hi;
    end
  end

  assign top = r[NUMBER-1];

endmodule

// median_seq: sequencer around med_core.
// Latency: DO/DSO appear 45 clock edges after the edge capturing the 9th sample.
// No backpressure: DSI bursts are accepted in IDLE/DONE only; PASS ignores DSI.
module median_seq #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] DI,
  input  logic             DSI,
  output logic [WIDTH-1:0] DO,
  output logic             DSO
`ifdef MEDIAN_SEQ_PROTO_CHECK_EN
  ,
  output logic             ERR
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PASS,
    EMIT,
    DONE
  } state_t;

  state_t           state;
  logic [3:0]       cnt;
  logic [3:0]       step;
  logic [2:0]       pass;
  logic             hold;
  logic             accept;
  logic             core_dsi;
  logic             core_byp;
  logic [WIDTH-1:0] core_top;

  // a sample is taken in IDLE/DONE only at the start of a fresh burst
  // (hold blocks a DSI left high from the previous burst), and every DSI cycle in LOAD
  always_comb begin
    accept = 1'b0;
    if ((state == IDLE || state == DONE) && DSI && !hold) begin
      accept = 1'b1;
    end else if (state == LOAD && DSI) begin
      accept = 1'b1;
    end
  end

  // the first sample of a burst is shifted in the same cycle DSI is seen,
  // so the core load strobe follows acceptance rather than the registered state
  always_comb begin
    core_dsi = accept;
    core_byp = (state != PASS) || (step == 4'd8);
  end

  med_core #(
    .WIDTH  (WIDTH),
    .NUMBER (9)
  ) u_core (
    .clk (CLK),
    .dsi (core_dsi),
    .byp (core_byp),
    .di  (DI),
    .top (core_top)
  );

  // main FSM with registered DO/DSO; pass/step schedule the 4.9+8 sweep cycles
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
      cnt   <= '0;
      step  <= '0;
      pass  <= '0;
      hold  <= 1'b0;
      DO    <= '0;
      DSO   <= 1'b0;
    end else begin
      DSO <= 1'b0;
      if (!DSI) begin
        hold <= 1'b0;
      end
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            state <= LOAD;
            cnt   <= 4'd1;
          end else begin
            state <= IDLE;
          end
        end
        LOAD: begin
          if (DSI) begin
            if (cnt == 4'd8) begin
              state <= PASS;
              cnt   <= '0;
              step  <= '0;
              pass  <= '0;
              hold  <= 1'b1;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end else begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        PASS: begin
          if (pass == 3'd4 && step == 4'd7) begin
            state <= EMIT;
            step  <= '0;
            pass  <= '0;
          end else if (step == 4'd8) begin
            step <= '0;
            pass <= pass + 3'd1;
          end else begin
            step <= step + 4'd1;
          end
        end
        EMIT: begin
          // top settled on the previous edge; the core shifting now does not matter
          DO    <= core_top;
          DSO   <= 1'b1;
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MEDIAN_SEQ_PROTO_CHECK_EN
  // sticky flag: short burst, DSI held past the 9th sample, or DSI during the sweep
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      ERR <= 1'b0;
    end else if ((state == LOAD && !DSI) ||
                 ((state == PASS || state == EMIT) && DSI)) begin
      ERR <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_median_seq.sv
// Testbench for median_seq: scoreboard of (median, DSO cycle) pairs pushed per burst,
// checked by a negedge monitor; scenario tasks cover reset, ordering, ties,
// back-to-back bursts, mid-flight reset, aborts and stray DSI pulses.
module tb_median_seq;

  logic       CLK;
  logic       nRST;
  logic [7:0] DI;
  logic       DSI;
  logic [7:0] DO;
  logic       DSO;
`ifdef MEDIAN_SEQ_PROTO_CHECK_EN
  logic       ERR;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int dso_count = 0;
  int last_t9 = 0;
  logic [7:0] last_med = 8'd0;
  logic [7:0] exp_val [$];
  int         exp_cyc [$];
  logic [7:0] v [9];

  median_seq #(.WIDTH(8)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .DI   (DI),
    .DSI  (DSI),
    .DO   (DO),
    .DSO  (DSO)
`ifdef MEDIAN_SEQ_PROTO_CHECK_EN
    ,
    .ERR  (ERR)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [7:0] model_median(input logic [7:0] a [9]);
    logic [7:0] s [9];
    logic [7:0] t;
    s = a;
    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < 8 - i; j++) begin
        if (s[j] > s[j+1]) begin
          t = s[j];
          s[j] = s[j+1];
          s[j+1] = t;
        end
      end
    end
    return s[4];
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic monitor();
    logic       prev_dso;
    logic [7:0] ev;
    int         ec;
    prev_dso = 1'b0;
    forever begin
      @(negedge CLK);
      if (DSO === 1'b1) begin
        dso_count++;
        total++;
        if (prev_dso) begin
          bad++;
          $display("FAIL dso_double: DSO high two cycles running at cycle %0d", cyc);
        end
        total++;
        if (exp_val.size() == 0) begin
          bad++;
          $display("FAIL dso_unexpected: DSO at cycle %0d with DO=%0d, none expected", cyc, DO);
        end else begin
          ev = exp_val.pop_front();
          ec = exp_cyc.pop_front();
          total++;
          if (DO !== ev) begin
            bad++;
            $display("FAIL median_value: got DO=%0d want %0d", DO, ev);
          end
          if (cyc !== ec) begin
            bad++;
            $display("FAIL dso_timing: DSO at cycle %0d want %0d", cyc, ec);
          end
        end
      end
      prev_dso = (DSO === 1'b1);
    end
  endtask

  // drives nine samples; leaves DSI high after the last edge
  task automatic send9(input logic [7:0] a [9], input bit push);
    for (int i = 0; i < 9; i++) begin
      DSI = 1'b1;
      DI  = a[i];
      tick();
    end
    last_t9 = cyc;
    if (push) begin
      last_med = model_median(a);
      exp_val.push_back(last_med);
      exp_cyc.push_back(last_t9 + 45);
    end
  endtask

  task automatic idle(input int n);
    DSI = 1'b0;
    DI  = 8'h00;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_val.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    total++;
    if (exp_val.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: %0d results still pending after %0d cycles", exp_val.size(), budget);
      exp_val.delete();
      exp_cyc.delete();
    end
    idle(2);
  endtask

  task automatic do_reset(input int n);
    nRST = 1'b0;
    for (int i = 0; i < n; i++) tick();
    nRST = 1'b1;
    last_med = 8'd0;
  endtask

  task automatic test_reset();
    DSI = 1'b0;
    DI  = 8'h00;
    do_reset(3);
    total++;
    if (DO !== 8'd0) begin
      bad++;
      $display("FAIL reset_do: got %0d want 0", DO);
    end
    total++;
    if (DSO !== 1'b0) begin
      bad++;
      $display("FAIL reset_dso: got %b want 0", DSO);
    end
`ifdef MEDIAN_SEQ_PROTO_CHECK_EN
    total++;
    if (ERR !== 1'b0) begin
      bad++;
      $display("FAIL reset_err: got %b want 0", ERR);
    end
`endif
    idle(2);
  endtask

  task automatic test_ascending();
    v = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    send9(v, 1'b1);
    idle(1);
    wait_drain(80);
  endtask

  task automatic test_back_to_back();
    int t1;
    v = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    send9(v, 1'b1);
    t1 = last_t9;
    DSI = 1'b0;
    while (cyc < t1 + 45) tick();
    v = '{8'd200, 8'd3, 8'd17, 8'd255, 8'd0, 8'd42, 8'd99, 8'd42, 8'd8};
    send9(v, 1'b1);
    total++;
    if (last_t9 - t1 !== 54) begin
      bad++;
      $display("FAIL b2b_spacing: burst gap %0d want 54", last_t9 - t1);
    end
    idle(1);
    wait_drain(150);
  endtask

  task automatic test_ties();
    v = '{8'd7, 8'd7, 8'd7, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255};
    send9(v, 1'b1);
    idle(1);
    wait_drain(80);
    v = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
    send9(v, 1'b1);
    idle(1);
    wait_drain(80);
  endtask

  // DSI kept high past the 9th sample must not start a new burst
  task automatic test_long_dsi();
    v = '{8'd30, 8'd10, 8'd90, 8'd70, 8'd50, 8'd20, 8'd80, 8'd60, 8'd40};
    send9(v, 1'b1);
    for (int i = 0; i < 5; i++) begin
      DI = 8'd250;
      tick();
    end
    idle(1);
    wait_drain(80);
`ifdef MEDIAN_SEQ_PROTO_CHECK_EN
    total++;
    if (ERR !== 1'b1) begin
      bad++;
      $display("FAIL long_dsi_err: got %b want 1", ERR);
    end
    do_reset(1);
    idle(1);
`endif
  endtask

  task automatic test_reset_midflight();
    int d0;
    v = '{8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66, 8'd77, 8'd88, 8'd99};
    send9(v, 1'b0);
    DSI = 1'b0;
    while (cyc < last_t9 + 21) tick();
    d0 = dso_count;
    do_reset(1);
    total++;
    if (DO !== 8'd0) begin
      bad++;
      $display("FAIL midreset_do: got %0d want 0", DO);
    end
    idle(60);
    total++;
    if (dso_count !== d0) begin
      bad++;
      $display("FAIL midreset_no_dso: saw %0d pulses want 0", dso_count - d0);
    end
    total++;
    if (DO !== 8'd0) begin
      bad++;
      $display("FAIL midreset_do_hold: got %0d want 0", DO);
    end
    v = '{8'd90, 8'd10, 8'd70, 8'd30, 8'd50, 8'd20, 8'd80, 8'd40, 8'd60};
    send9(v, 1'b1);
    idle(1);
    wait_drain(80);
  endtask

  task automatic test_abort();
    int d0;
    d0 = dso_count;
    for (int i = 0; i < 5; i++) begin
      DSI = 1'b1;
      DI  = 8'(i * 40 + 1);
      tick();
    end
    DSI = 1'b0;
`ifdef MEDIAN_SEQ_PROTO_CHECK_EN
    total++;
    if (ERR !== 1'b0) begin
      bad++;
      $display("FAIL abort_err_early: got %b want 0", ERR);
    end
`endif
    tick();
`ifdef MEDIAN_SEQ_PROTO_CHECK_EN
    total++;
    if (ERR !== 1'b1) begin
      bad++;
      $display("FAIL abort_err: got %b want 1", ERR);
    end
`endif
    idle(70);
    total++;
    if (dso_count !== d0) begin
      bad++;
      $display("FAIL abort_no_dso: saw %0d pulses want 0", dso_count - d0);
    end
    total++;
    if (DO !== last_med) begin
      bad++;
      $display("FAIL abort_do_hold: got %0d want %0d", DO, last_med);
    end
`ifdef MEDIAN_SEQ_PROTO_CHECK_EN
    total++;
    if (ERR !== 1'b1) begin
      bad++;
      $display("FAIL abort_err_sticky: got %b want 1", ERR);
    end
    do_reset(1);
    total++;
    if (ERR !== 1'b0) begin
      bad++;
      $display("FAIL abort_err_clear: got %b want 0", ERR);
    end
    idle(1);
`endif
  endtask

  task automatic test_pass_pulse();
    v = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    send9(v, 1'b1);
    idle(10);
    DSI = 1'b1;
    DI  = 8'd200;
    tick();
    idle(1);
    wait_drain(80);
`ifdef MEDIAN_SEQ_PROTO_CHECK_EN
    total++;
    if (ERR !== 1'b1) begin
      bad++;
      $display("FAIL pass_pulse_err: got %b want 1", ERR);
    end
`endif
  endtask

  initial begin
    nRST = 1'b0;
    DSI  = 1'b0;
    DI   = 8'h00;
    fork
      monitor();
    join_none
    test_reset();
    test_ascending();
    test_back_to_back();
    test_ties();
    test_long_dsi();
    test_reset_midflight();
    test_abort();
    test_pass_pulse();
    idle(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
